fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: DPW, rv32i_pkg::DPW (32), datapath/PC width.
REQ-002 Parameter: RESET_PC, rv32i_pkg::RESET_PC (32'h0000_0000), first fetch address.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 PCF  in  DPW  current PC from fetch_stage_reg.
REQ-006 redirect_valid  in  1  taken branch/jump from execute.
REQ-007 redirect_pc  in  DPW  redirect target.
REQ-008 hazard_stall  in  1  decode stall request from hazard unit.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  DPW  request address, equals PCF.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  response data valid.
REQ-013 imem_rdata  in  32  response instruction.
REQ-014 instr_valid  out  1  instr_out valid to decode.
REQ-015 instr_out  out  32  fetched instruction.
REQ-016 PCNext  out  DPW  next PC to fetch_stage_reg.
REQ-017 stallF  out  1  hold fetch_stage_reg.
REQ-018 flushF  out  1  flush fetch_stage_reg.
REQ-019 flushD  out  1  bubble decode register.

Function
REQ-020 FSM states SHALL be BOOT, REQ, WAIT, HOLD, KILL; max one outstanding memory request.
REQ-021 BOOT: one cycle; flushF=1, flushD=1, stallF=0, PCNext=RESET_PC; next REQ.
REQ-022 REQ: imem_req=1, imem_addr=PCF, stallF=1; imem_gnt -> WAIT, else stay.
REQ-023 REQ + redirect_valid, no gnt: PCNext=redirect_pc, stallF=0, stay REQ (new address next cycle).
REQ-024 REQ + redirect_valid + gnt same cycle: PCNext=redirect_pc, stallF=0, -> KILL.
REQ-025 WAIT: imem_req=0, stallF=1 until imem_rvalid.
REQ-026 WAIT + rvalid, no redirect, !hazard_stall: instr_valid=1, instr_out=imem_rdata, PCNext=PCF+4, stallF=0, -> REQ.
REQ-027 WAIT + rvalid + hazard_stall: capture imem_rdata in hold buffer, instr_valid=1, stallF=1, -> HOLD.
REQ-028 HOLD: instr_valid=1, instr_out=buffer, stallF=1 while hazard_stall; on release PCNext=PCF+4, stallF=0, -> REQ.
REQ-029 WAIT + redirect, no rvalid: PCNext=redirect_pc, stallF=0, -> KILL.
REQ-030 WAIT + redirect + rvalid same cycle: response dropped (instr_valid=0), PCNext=redirect_pc, stallF=0, -> REQ.
REQ-031 HOLD + redirect: buffer dropped, instr_valid=0, PCNext=redirect_pc, stallF=0, -> REQ.
REQ-032 KILL: imem_req=0, instr_valid=0; on rvalid discard data -> REQ; redirect in KILL updates PC (stallF=0), stays KILL.
REQ-033 redirect_valid SHALL take priority over hazard_stall and imem_rvalid in every state except BOOT (ignored in BOOT).
REQ-034 flushD SHALL equal redirect_valid (outside BOOT), combinational; flushF SHALL be 1 only in BOOT.
REQ-035 PCF+4 SHALL be modulo 2^DPW (32'hFFFF_FFFC -> 0); PCNext[1:0] SHALL always be 2'b00 (redirect_pc[1:0] forced to 0).
REQ-036 When stallF=1 and no redirect, PCNext SHALL equal PCF.

Reset
REQ-037 rst_n low SHALL immediately force state BOOT, imem_req=0, instr_valid=0, instr_out=0, hold buffer=0, stallF=1, flushF=1, flushD=1, PCNext=RESET_PC.
REQ-038 Reset mid-request SHALL abandon outstanding response; responses before first post-reset REQ grant SHALL be ignored.

Structure
REQ-039 DPW, RESET_PC and the fetch_state_e enum SHALL live in rv32i_pkg.
REQ-040 Single module, no sub-modules; hold buffer and FSM in one always_ff, outputs in one always_comb.

Verification
REQ-041 Reset release, gnt and rvalid (rdata=32'h0000_0013) one cycle after each request -> BOOT PCNext=0, first instr_valid with 32'h13, PCNext=4, then 8.
REQ-042 rvalid with hazard_stall=1 for 3 cycles -> instr_valid held 4 cycles with same data, stallF=1 throughout, PCNext=PCF+4 on release cycle.
REQ-043 redirect_valid (redirect_pc=32'h0000_0100) in WAIT, rvalid two cycles later -> flushD=1 one cycle, stale data never valid, next imem_addr=32'h100.
REQ-044 redirect and rvalid same cycle in WAIT -> instr_valid=0, PCNext=32'h100, state REQ.
REQ-045 PCF=32'hFFFF_FFFC, response returned -> PCNext=0; redirect_pc=32'h0000_0103 -> PCNext=32'h100.
REQ-046 rst_n asserted in WAIT, rvalid during reset and one cycle after -> outputs at reset values, no instr_valid, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath width, reset vector and fetch FSM states.
package rv32i_pkg;

    localparam int          DPW      = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        KILL
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences single-outstanding instruction-memory requests and steers the PC register.
module fetch_ctrl #(
    parameter int             DPW      = rv32i_pkg::DPW,
    parameter logic [DPW-1:0] RESET_PC = rv32i_pkg::RESET_PC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DPW-1:0] PCF,
    input  logic           redirect_valid,
    input  logic [DPW-1:0] redirect_pc,
    input  logic           hazard_stall,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [31:0]    imem_rdata,
    output logic           instr_valid,
    output logic [31:0]    instr_out,
    output logic [DPW-1:0] PCNext,
    output logic           stallF,
    output logic           flushF,
    output logic           flushD
);
    import rv32i_pkg::*;

    localparam logic [DPW-1:0] ALIGN_MASK = ~DPW'(3);

    fetch_state_e   state_q, state_d;
    logic [31:0]    hold_q, hold_d;
    logic [DPW-1:0] pc_plus4;
    logic [DPW-1:0] redir_pc;
    logic [DPW-1:0] pc_next_raw;

    assign pc_plus4 = PCF + DPW'(4);
    assign redir_pc = redirect_pc & ALIGN_MASK;
    assign PCNext   = pc_next_raw & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // A redirect always wins over responses and decode stalls; only BOOT ignores it.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        imem_req    = 1'b0;
        imem_addr   = PCF;
        instr_valid = 1'b0;
        instr_out   = '0;
        pc_next_raw = PCF;
        stallF      = 1'b1;
        flushF      = 1'b0;
        flushD      = redirect_valid;

        unique case (state_q)
            BOOT: begin
                flushF      = 1'b1;
                flushD      = 1'b1;
                stallF      = 1'b0;
                pc_next_raw = RESET_PC;
                state_d     = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    pc_next_raw = redir_pc;
                    stallF      = 1'b0;
                    if (imem_gnt) state_d = KILL;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next_raw = redir_pc;
                    stallF      = 1'b0;
                    state_d     = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    instr_valid = 1'b1;
                    instr_out   = imem_rdata;
                    if (hazard_stall) begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        pc_next_raw = pc_plus4;
                        stallF      = 1'b0;
                        state_d     = REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next_raw = redir_pc;
                    stallF      = 1'b0;
                    state_d     = REQ;
                end else begin
                    instr_valid = 1'b1;
                    instr_out   = hold_q;
                    if (!hazard_stall) begin
                        pc_next_raw = pc_plus4;
                        stallF      = 1'b0;
                        state_d     = REQ;
                    end
                end
            end
            KILL: begin
                if (redirect_valid) begin
                    pc_next_raw = redir_pc;
                    stallF      = 1'b0;
                end
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = BOOT;
        endcase

        // Outputs follow rst_n immediately, not just at the next edge.
        if (!rst_n) begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            instr_out   = '0;
            stallF      = 1'b1;
            flushF      = 1'b1;
            flushD      = 1'b1;
            pc_next_raw = RESET_PC;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl; the bench itself plays the PC register and instruction memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hazard_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] PCNext;
    logic        stallF;
    logic        flushF;
    logic        flushD;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    fetch_ctrl #(.DPW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .hazard_stall(hazard_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out),
        .PCNext(PCNext), .stallF(stallF), .flushF(flushF), .flushD(flushD)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle to the falling edge for sampling.
    task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                 input logic redir, input logic [31:0] rpc, input logic hazard);
        imem_gnt       = gnt;
        imem_rvalid    = rvalid;
        imem_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        hazard_stall   = hazard;
        @(negedge clk);
    endtask

    task automatic nextCycle();
        logic        stall_s;
        logic [31:0] next_s;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                checkOutput("sb_instr", instr_out, exp_q[0]);
                if (!stallF) void'(exp_q.pop_front());
            end
        end
        if ((redirect_valid && rst_n) || !rst_n) exp_q.delete();
        stall_s = stallF;
        next_s  = PCNext;
        @(posedge clk);
        #1;
        if (!rst_n) PCF = 32'h0000_0000;
        else if (!stall_s) PCF = next_s;
    endtask

    task automatic fetchOne(input logic [31:0] data);
        logic [31:0] pc_s;
        pc_s = PCF;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("req", {31'd0, imem_req}, 32'd1);
        checkOutput("addr", imem_addr, pc_s);
        nextCycle();
        exp_q.push_back(data);
        applyStimulus(1'b0, 1'b1, data, 1'b0, '0, 1'b0);
        checkOutput("resp_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("resp_stallF", {31'd0, stallF}, 32'd0);
        checkOutput("resp_pcnext", PCNext, pc_s + 32'd4);
        nextCycle();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"},    {31'd0, imem_req},    32'd0);
        checkOutput({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        checkOutput({tag, "_instr"},  instr_out,            32'd0);
        checkOutput({tag, "_stallF"}, {31'd0, stallF},      32'd1);
        checkOutput({tag, "_flushF"}, {31'd0, flushF},      32'd1);
        checkOutput({tag, "_flushD"}, {31'd0, flushD},      32'd1);
        checkOutput({tag, "_pcnext"}, PCNext,               32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        PCF   = 32'h0000_0000;

        // Reset state, with a stray response that must be ignored.
        applyStimulus(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, '0, 1'b0);
        checkReset("rst");
        nextCycle();
        rst_n = 1'b1;

        // Boot then two sequential fetches.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("boot_flushF", {31'd0, flushF}, 32'd1);
        checkOutput("boot_stallF", {31'd0, stallF}, 32'd0);
        checkOutput("boot_pcnext", PCNext, 32'd0);
        nextCycle();
        fetchOne(32'h0000_0013);
        fetchOne(32'h0010_0093);

        // Response under a 3-cycle decode stall.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("h_addr", imem_addr, 32'h8);
        nextCycle();
        exp_q.push_back(32'h0020_0113);
        applyStimulus(1'b0, 1'b1, 32'h0020_0113, 1'b0, '0, 1'b1);
        checkOutput("h0_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("h0_stallF", {31'd0, stallF}, 32'd1);
        checkOutput("h0_pcnext", PCNext, 32'h8);
        nextCycle();
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
            checkOutput($sformatf("h%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            checkOutput($sformatf("h%0d_stallF", i), {31'd0, stallF}, 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("h3_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("h3_stallF", {31'd0, stallF}, 32'd0);
        checkOutput("h3_pcnext", PCNext, 32'hC);
        nextCycle();

        // Redirect while waiting; the late response is stale.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b0);
        checkOutput("w_redir_flushD", {31'd0, flushD}, 32'd1);
        checkOutput("w_redir_pcnext", PCNext, 32'h100);
        checkOutput("w_redir_stallF", {31'd0, stallF}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("kill_flushD", {31'd0, flushD}, 32'd0);
        checkOutput("kill_req", {31'd0, imem_req}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
        checkOutput("kill_valid", {31'd0, instr_valid}, 32'd0);
        nextCycle();
        fetchOne(32'h0030_0193);

        // Redirect and response in the same cycle.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0001, 1'b1, 32'h100, 1'b0);
        checkOutput("same_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("same_pcnext", PCNext, 32'h100);
        nextCycle();
        fetchOne(32'h0040_0213);

        // Redirect in REQ without grant, then PC wrap at the top of memory.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        checkOutput("req_redir_stallF", {31'd0, stallF}, 32'd0);
        checkOutput("req_redir_pcnext", PCNext, 32'hFFFF_FFFC);
        nextCycle();
        fetchOne(32'h0050_0293);
        checkOutput("wrap_pcf", PCF, 32'h0);

        // Misaligned redirect together with grant.
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h0000_0103, 1'b0);
        checkOutput("align_pcnext", PCNext, 32'h100);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0002, 1'b0, '0, 1'b0);
        checkOutput("align_kill_valid", {31'd0, instr_valid}, 32'd0);
        nextCycle();
        fetchOne(32'h0060_0313);

        // Redirect drops the held instruction.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        exp_q.push_back(32'h0070_0393);
        applyStimulus(1'b0, 1'b1, 32'h0070_0393, 1'b0, '0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1);
        checkOutput("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("hold_redir_pcnext", PCNext, 32'h200);
        checkOutput("hold_redir_stallF", {31'd0, stallF}, 32'd0);
        nextCycle();
        fetchOne(32'h0080_0413);

        // Second redirect while killing an outstanding request.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h300, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h340, 1'b0);
        checkOutput("kill_redir_pcnext", PCNext, 32'h340);
        checkOutput("kill_redir_stallF", {31'd0, stallF}, 32'd0);
        checkOutput("kill_redir_req", {31'd0, imem_req}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0003, 1'b0, '0, 1'b0);
        checkOutput("kill2_valid", {31'd0, instr_valid}, 32'd0);
        nextCycle();
        fetchOne(32'h0090_0493);

        // Reset asserted while a response is outstanding.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0004, 1'b0, '0, 1'b0);
        checkReset("midrst");
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0005, 1'b0, '0, 1'b0);
        checkOutput("reboot_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reboot_flushF", {31'd0, flushF}, 32'd1);
        checkOutput("reboot_pcnext", PCNext, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0006, 1'b0, '0, 1'b0);
        checkOutput("rereq_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rereq_addr", imem_addr, 32'h0);
        nextCycle();
        fetchOne(32'h00A0_0513);

        checkOutput("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
